pipelined_shifter: RTL
======================

PIPELINED_SHIFTER -- requirements
Module: pipelined_shifter

Interface
REQ-001 Parameter WIDTH, default 8, data width; SHALL be a power of two, 4..64.
REQ-002 Parameter AW, default $clog2(WIDTH), shift-amount width and pipeline depth; SHALL NOT be overridden.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  request present on in_data/in_amt/in_mode.
REQ-006 in_ready  output  1  block accepts the request this cycle.
REQ-007 in_data  input  WIDTH  operand.
REQ-008 in_amt  input  AW  shift/rotate distance, 0..WIDTH-1.
REQ-009 in_mode  input  2  00 ROR, 01 ROL, 10 SRL (logical right), 11 SRA (arithmetic right).
REQ-010 out_valid  output  1  result present on out_data.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 out_data  output  WIDTH  shifted/rotated result.

Function
REQ-013 A request SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-014 Pipeline SHALL have AW register stages; stage k (0..AW-1) SHALL apply a distance of 2^k when bit k of the carried amount is 1, else pass data unchanged.
REQ-015 Each stage SHALL carry valid, data, amount and mode forward with the data.
REQ-016 ROR SHALL map result bit i = operand bit (i+amt) mod WIDTH; ROL bit i = operand bit (i-amt) mod WIDTH.
REQ-017 SRL SHALL fill vacated MSBs with 0; SRA SHALL fill them with operand bit WIDTH-1 captured at acceptance.
REQ-018 in_amt = 0 SHALL return in_data unchanged in every mode.
REQ-019 Pipeline SHALL advance as a whole when adv = !out_valid || out_ready; otherwise every stage SHALL hold.
REQ-020 in_ready SHALL equal adv (combinational, no dependence on in_valid).
REQ-021 With no stall, the result SHALL appear on out_valid/out_data exactly AW cycles after acceptance.
REQ-022 Results SHALL leave in acceptance order; none dropped or duplicated.
REQ-023 Throughput SHALL be one result per cycle while out_ready stays high.
REQ-024 out_data and out_valid SHALL be driven directly from the last stage registers.
REQ-025 out_data SHALL hold stable while out_valid && !out_ready.
REQ-026 Bubbles (invalid stages) SHALL advance with the pipe; they are not squeezed out.
REQ-027 Simultaneous output handoff and input acceptance in one cycle SHALL both occur.

Reset
REQ-028 rst_n low SHALL immediately clear all stage valid bits; out_valid = 0, out_data = 0.
REQ-029 Data/amount/mode stage registers SHALL also reset to 0.
REQ-030 in_ready SHALL be 1 during and after reset, since out_valid = 0.
REQ-031 Reset mid-operation SHALL discard all in-flight requests; no result from before reset SHALL emerge.

Structure
REQ-032 Shared package pipelined_shifter_pkg SHALL hold the mode encodings MODE_ROR, MODE_ROL, MODE_SRL, MODE_SRA.
REQ-033 One sub-module shifter_stage (parameters WIDTH, DIST) SHALL implement a single registered 2^k stage with hold enable; top SHALL instantiate AW of them in a generate loop.

Verification
REQ-034 WIDTH=8: ROR, data 8'hB1, amt 3, out_ready=1 -> 8'h36 exactly 3 cycles after acceptance.
REQ-035 WIDTH=8: ROL 8'hB1 amt 3 -> 8'h8D; SRL 8'hB1 amt 3 -> 8'h16; SRA 8'hB1 amt 3 -> 8'hF6; SRA 8'h71 amt 7 -> 8'h00.
REQ-036 Amt 0 in all four modes on 8'hA5 -> 8'hA5 each; back-to-back requests -> four results on four consecutive cycles.
REQ-037 Stream of 6 requests with out_ready=0 from cycle 2 to cycle 7 -> in_ready=0 while stalled, out_data constant, all 6 results later delivered in order.
REQ-038 Assert rst_n=0 with 3 requests in flight -> out_valid=0 in the same cycle; after release no stale result appears and the next request returns in 3 cycles.
REQ-039 Random regression, WIDTH 4, 8, 32, all modes and amounts, random out_ready -> every result matches a reference model, in order.

Source files
------------

// File: rtl/pipelined_shifter_pkg.sv
// Shared definitions for the pipelined shifter/rotator: operation encodings.
package pipelined_shifter_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_ROR = 2'b00;
  localparam mode_t MODE_ROL = 2'b01;
  localparam mode_t MODE_SRL = 2'b10;
  localparam mode_t MODE_SRA = 2'b11;

endpackage

// File: rtl/pipelined_shifter_stage.sv
// One registered pipeline stage: conditionally shifts/rotates by DIST when the
// matching amount bit is set, and carries valid/amount/mode alongside the data.
module shifter_stage
  import pipelined_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIST  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en_i,
  input  logic                       valid_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic [$clog2(WIDTH)-1:0]   amt_i,
  input  mode_t                      mode_i,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(WIDTH)-1:0]   amt_o,
  output mode_t                      mode_o
);

  localparam int unsigned AW  = $clog2(WIDTH);
  localparam int unsigned BIT = $clog2(DIST);

  logic [WIDTH-1:0] shifted_c;
  logic [WIDTH-1:0] data_d;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [AW-1:0]    amt_q;
  mode_t            mode_q;

  // SRA keeps the MSB in every stage, so the sign captured at acceptance propagates.
  always_comb begin
    shifted_c = data_i;
    case (mode_i)
      MODE_ROR: shifted_c = (data_i >> DIST) | (data_i << (WIDTH - DIST));
      MODE_ROL: shifted_c = (data_i << DIST) | (data_i >> (WIDTH - DIST));
      MODE_SRL: shifted_c = data_i >> DIST;
      default:  shifted_c = WIDTH'($signed(data_i) >>> DIST);
    endcase
    data_d = amt_i[BIT] ? shifted_c : data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      mode_q  <= MODE_ROR;
    end else if (en_i) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      amt_q   <= amt_i;
      mode_q  <= mode_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign amt_o   = amt_q;
  assign mode_o  = mode_q;

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter/rotator: AW stages of power-of-two distances,
// whole-pipe stall when the output is held by the consumer.
module pipelined_shifter
  import pipelined_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             adv_c;
  logic             valid_s [AW+1];
  logic [WIDTH-1:0] data_s  [AW+1];
  logic [AW-1:0]    amt_s   [AW+1];
  mode_t            mode_s  [AW+1];
  logic             unused_tail;

  // Every stage moves together; a held output freezes the whole pipe, bubbles included.
  assign adv_c    = !out_valid || out_ready;
  assign in_ready = adv_c;

  assign valid_s[0] = in_valid;
  assign data_s[0]  = in_data;
  assign amt_s[0]   = in_amt;
  assign mode_s[0]  = mode_t'(in_mode);

  for (genvar k = 0; k < AW; k++) begin : g_stage
    shifter_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (adv_c),
      .valid_i (valid_s[k]),
      .data_i  (data_s[k]),
      .amt_i   (amt_s[k]),
      .mode_i  (mode_s[k]),
      .valid_o (valid_s[k+1]),
      .data_o  (data_s[k+1]),
      .amt_o   (amt_s[k+1]),
      .mode_o  (mode_s[k+1])
    );
  end

  assign out_valid   = valid_s[AW];
  assign out_data    = data_s[AW];
  assign unused_tail = ^{amt_s[AW], mode_s[AW]};

endmodule
